apb_access_sequencer: RTL

//  APB slave-side access controller for the timer register block. Tracks SETUP/ACCESS phases,

---
 rtl/apb_timer_pkg.sv | 13 +
 rtl/apb_wait_counter.sv | 36 +++
 rtl/apb_access_sequencer.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/apb_timer_pkg.sv
// Shared types and constants for the APB timer register block.
// Holds the access sequencer state encoding and the register stride.
package apb_timer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } apb_seq_state_e;

  localparam int REG_BYTES = 4;

endpackage

// File: rtl/apb_wait_counter.sv
// Loadable down-counter for APB wait-state insertion.
// Ports: PCLK, PRESETn, load, load_val, dec, zero (cnt == 0).
module apb_wait_counter #(
  parameter int WAIT_W = 3
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              load,
  input  logic [WAIT_W-1:0] load_val,
  input  logic              dec,
  output logic              zero
);

  logic [WAIT_W-1:0] cnt_q;
  logic [WAIT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && cnt_q != '0) begin
      cnt_d = cnt_q - WAIT_W'(1);
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/apb_access_sequencer.sv
// APB slave access sequencer for the timer registers: programmable waits,
// PREADY/PSLVERR/PRDATA, one-cycle reg_wr_en/reg_rd_en strobes, reg_idx, reg_wdata.
// Inputs: PCLK, PRESETn, PSEL, PENABLE, PWRITE, PADDR, PWDATA, wait_cfg, reg_rdata.
// Build option: APB_SLVERR_EN drives PSLVERR on bad addresses (else tied 0).
module apb_access_sequencer
  import apb_timer_pkg::*;
#(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 8,
  parameter int WAIT_W   = 3
) (
  input  logic                        PCLK,
  input  logic                        PRESETn,
  input  logic                        PSEL,
  input  logic                        PENABLE,
  input  logic                        PWRITE,
  input  logic [ADDR_W-1:0]           PADDR,
  input  logic [DATA_W-1:0]           PWDATA,
  input  logic [WAIT_W-1:0]           wait_cfg,
  input  logic [DATA_W-1:0]           reg_rdata,
  output logic                        PREADY,
  output logic                        PSLVERR,
  output logic [DATA_W-1:0]           PRDATA,
  output logic                        reg_wr_en,
  output logic                        reg_rd_en,
  output logic [$clog2(NUM_REGS)-1:0] reg_idx,
  output logic [DATA_W-1:0]           reg_wdata
);

  localparam int IDX_W = $clog2(NUM_REGS);
  localparam logic [ADDR_W-1:0] ADDR_LIM =
    ADDR_W'(REG_BYTES * NUM_REGS);

  apb_seq_state_e state_q, state_d;
  logic             wr_q, wr_d;
  logic             err_q, err_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             pready_q, pready_d;
  logic             slverr_q, slverr_d;
  logic             wr_en_q, wr_en_d;
  logic             rd_en_q, rd_en_d;

  logic             cnt_load;
  logic             cnt_dec;
  logic             cnt_zero;
  logic             addr_err;

  assign addr_err = (PADDR[1:0] != 2'b00) || (PADDR >= ADDR_LIM);

  // The counter holds the wait cycles still owed after the current
  // one, so it is loaded with wait_cfg-1; wait_cfg=0 skips ACCESS.
  apb_wait_counter #(
    .WAIT_W (WAIT_W)
  ) u_wait_cnt (
    .PCLK     (PCLK),
    .PRESETn  (PRESETn),
    .load     (cnt_load),
    .load_val (wait_cfg - WAIT_W'(1)),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    wr_d     = wr_q;
    err_d    = err_q;
    idx_d    = idx_q;
    pready_d = 1'b0;
    slverr_d = 1'b0;
    wr_en_d  = 1'b0;
    rd_en_d  = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          cnt_load = 1'b1;
          wr_d     = PWRITE;
          err_d    = addr_err;
          idx_d    = PADDR[IDX_W+1:2];
          state_d  = (wait_cfg == '0) ? DONE : ACCESS;
        end
      end
      ACCESS: begin
        if (!PSEL) begin
          state_d = IDLE;
        end else if (PENABLE) begin
          if (cnt_zero) begin
            state_d = DONE;
          end else begin
            cnt_dec = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered: decode them for the state being entered.
    if (state_d == DONE) begin
      pready_d = 1'b1;
      wr_en_d  = wr_d && !err_d;
      rd_en_d  = !wr_d && !err_d;
`ifdef APB_SLVERR_EN
      slverr_d = err_d;
`else
      slverr_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q  <= IDLE;
      wr_q     <= 1'b0;
      err_q    <= 1'b0;
      idx_q    <= '0;
      pready_q <= 1'b0;
      slverr_q <= 1'b0;
      wr_en_q  <= 1'b0;
      rd_en_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_q     <= wr_d;
      err_q    <= err_d;
      idx_q    <= idx_d;
      pready_q <= pready_d;
      slverr_q <= slverr_d;
      wr_en_q  <= wr_en_d;
      rd_en_q  <= rd_en_d;
    end
  end

  assign PREADY    = pready_q;
  assign PSLVERR   = slverr_q;
  assign reg_wr_en = wr_en_q;
  assign reg_rd_en = rd_en_q;
  assign reg_idx   = idx_q;
  assign reg_wdata = PWDATA;
  // reg_rdata is combinational on reg_idx, so it cannot be registered
  // without costing a cycle on zero-wait reads.
  assign PRDATA    = rd_en_q ? reg_rdata : '0;

endmodule
